// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM request arbiter.
// Defines the request payload type and the round-robin pick function.
package sram_arb_pkg;

  localparam int SramAw = 12;
  localparam int SramDw = 32;
  localparam int MaxReq = 8;

  typedef struct packed {
    logic                  we;
    logic [SramAw-1:0]     addr;
    logic [SramDw-1:0]     wdata;
    logic [SramDw/8-1:0]   wmask;
  } sram_req_t;

  // First asserted request at or after ptr, wrapping at num_req; 0 when none.
  function automatic logic [2:0] rr_pick(input logic [MaxReq-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int unsigned       num_req);
    logic [2:0] pick;
    logic [2:0] cand;
    logic       found;
    pick  = 3'd0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      cand = 3'((32'(ptr) + i) % num_req);
      if (i < num_req && !found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sram_arb_tag_fifo.sv
// Tag FIFO holding the requester id of every granted-but-unanswered request.
// Supports push and pop in the same cycle; head is read combinationally.
module sram_arb_tag_fifo #(
  parameter int Depth = 2,
  parameter int Width = 1,
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int CntW = PtrW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_reg [Depth];
  logic [PtrW-1:0]  wr_ptr_reg;
  logic [PtrW-1:0]  rd_ptr_reg;
  logic [CntW-1:0]  count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == CntW'(Depth));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = mem_reg[rd_ptr_reg];

  // A pop in the same cycle frees the slot a full push needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == PtrW'(Depth - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PtrW'(Depth - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NumReq requesters,
// routing each in-order memory response back to the requester that issued it.
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NumReq      = 2,
  parameter int SramAw      = 12,
  parameter int SramDw      = 32,
  parameter int Outstanding = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NumReq-1:0]          req_i,
  output logic [NumReq-1:0]          gnt_o,
  input  logic [NumReq-1:0]          we_i,
  input  logic [NumReq*SramAw-1:0]   addr_i,
  input  logic [NumReq*SramDw-1:0]   wdata_i,
  input  logic [NumReq*SramDw/8-1:0] wmask_i,
  output logic [NumReq-1:0]          rvalid_o,
  output logic [SramDw-1:0]          rdata_o,
  output logic                       mem_req_o,
  input  logic                       mem_gnt_i,
  output logic                       mem_we_o,
  output logic [SramAw-1:0]          mem_addr_o,
  output logic [SramDw-1:0]          mem_wdata_o,
  output logic [SramDw/8-1:0]        mem_wmask_o,
  input  logic [SramDw-1:0]          mem_rdata_i,
  input  logic                       mem_rvalid_i,
  output logic                       err_o
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int MskW = SramDw / 8;
  localparam int PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
  localparam int CntW = PtrW + 1;

  logic [SramAw-1:0] addr_arr  [NumReq];
  logic [SramDw-1:0] wdata_arr [NumReq];
  logic [MskW-1:0]   wmask_arr [NumReq];

  logic [IdxW-1:0]   rr_ptr_reg;
  logic              err_reg;
  logic [IdxW-1:0]   winner;
  logic [MaxReq-1:0] req_ext;
  logic              any_req;
  logic              room;
  logic              handshake;
  logic              pop;
  logic [IdxW-1:0]   tag_head;
  logic              tag_full;
  logic              tag_empty;
  logic [CntW-1:0]   tag_count;

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_req
      assign addr_arr[gi]  = addr_i[gi*SramAw +: SramAw];
      assign wdata_arr[gi] = wdata_i[gi*SramDw +: SramDw];
      assign wmask_arr[gi] = wmask_i[gi*MskW +: MskW];
      assign gnt_o[gi]     = handshake && (winner == IdxW'(gi));
      assign rvalid_o[gi]  = pop && (tag_head == IdxW'(gi));
    end
  endgenerate

  always_comb begin
    req_ext              = '0;
    req_ext[NumReq-1:0]  = req_i;
    winner               = IdxW'(rr_pick(req_ext, 3'(rr_ptr_reg), NumReq));
  end

  // An in-flight response this cycle frees a slot, so a full FIFO can still accept.
  assign any_req   = |req_i;
  assign room      = (tag_count < CntW'(Outstanding)) || (tag_full && mem_rvalid_i);
  assign mem_req_o = !reset && any_req && room;
  assign handshake = mem_req_o && mem_gnt_i;
  assign pop       = !reset && mem_rvalid_i && !tag_empty;

  assign mem_we_o    = any_req ? we_i[winner]      : 1'b0;
  assign mem_addr_o  = any_req ? addr_arr[winner]  : '0;
  assign mem_wdata_o = any_req ? wdata_arr[winner] : '0;
  assign mem_wmask_o = any_req ? wmask_arr[winner] : '0;
  assign rdata_o     = mem_rdata_i;
  assign err_o       = err_reg;

  sram_arb_tag_fifo #(
    .Depth (Outstanding),
    .Width (IdxW)
  ) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (handshake),
    .push_data (winner),
    .pop       (pop),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr_reg <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
      end
      if (mem_rvalid_i && tag_empty) begin
        err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Testbench for sram_req_arbiter: per-cycle vector table for grants plus a
// scoreboard of expected responses checked against rvalid_o / rdata_o.
module tb_sram_req_arbiter;
  import sram_arb_pkg::*;

  localparam int NumReq      = 2;
  localparam int Outstanding = 2;
  localparam int MskW        = SramDw / 8;

  logic                       clock = 1'b0;
  logic                       reset = 1'b1;
  logic [NumReq-1:0]          req_i = '0;
  logic [NumReq-1:0]          gnt_o;
  logic [NumReq-1:0]          we_i = '0;
  logic [NumReq*SramAw-1:0]   addr_i = '0;
  logic [NumReq*SramDw-1:0]   wdata_i = '0;
  logic [NumReq*MskW-1:0]     wmask_i = '0;
  logic [NumReq-1:0]          rvalid_o;
  logic [SramDw-1:0]          rdata_o;
  logic                       mem_req_o;
  logic                       mem_gnt_i = 1'b1;
  logic                       mem_we_o;
  logic [SramAw-1:0]          mem_addr_o;
  logic [SramDw-1:0]          mem_wdata_o;
  logic [MskW-1:0]            mem_wmask_o;
  logic [SramDw-1:0]          mem_rdata_i = '0;
  logic                       mem_rvalid_i = 1'b0;
  logic                       err_o;

  sram_req_arbiter #(
    .NumReq(NumReq), .SramAw(SramAw), .SramDw(SramDw), .Outstanding(Outstanding)
  ) dut (
    .clock(clock), .reset(reset), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .wmask_i(wmask_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i),
    .mem_rvalid_i(mem_rvalid_i), .err_o(err_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       mgnt;
    logic       hold;
    logic [1:0] req;
    sram_req_t  p0;
    sram_req_t  p1;
    logic [1:0] exp_gnt;
    logic       exp_mreq;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] data;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  logic [31:0] pending[$];
  logic [31:0] mem_arr [4096];
  logic [31:0] shadow  [4096];
  logic        hold     = 1'b0;
  logic        spurious = 1'b0;
  int          errors   = 0;
  int          checks   = 0;

  function automatic sram_req_t rd(input logic [11:0] a);
    sram_req_t r;
    r.we = 1'b0; r.addr = a; r.wdata = '0; r.wmask = '0;
    return r;
  endfunction

  function automatic sram_req_t wr(input logic [11:0] a, input logic [31:0] d,
                                   input logic [3:0] m);
    sram_req_t r;
    r.we = 1'b1; r.addr = a; r.wdata = d; r.wmask = m;
    return r;
  endfunction

  task automatic add(input logic rst, input logic mgnt, input logic hld,
                     input logic [1:0] req, input sram_req_t p0, input sram_req_t p1,
                     input logic [1:0] eg, input logic em);
    vec_t v;
    v.rst = rst; v.mgnt = mgnt; v.hold = hld; v.req = req;
    v.p0 = p0; v.p1 = p1; v.exp_gnt = eg; v.exp_mreq = em;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural 1-cycle-latency SRAM: accepts on handshake, answers in order.
  initial begin
    logic        hs, we;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        rv;
    forever begin
      @(negedge clock);
      hs = mem_req_o && mem_gnt_i;
      we = mem_we_o; a = mem_addr_o; d = mem_wdata_o; m = mem_wmask_o;
      rv = mem_rvalid_i;
      @(posedge clock);
      if (rv && pending.size() > 0) void'(pending.pop_front());
      if (hs) begin
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (m[b]) mem_arr[a][8*b +: 8] = d[8*b +: 8];
          pending.push_back(32'h0);
        end else begin
          pending.push_back(mem_arr[a]);
        end
      end
      #2;
      if (reset) pending.delete();
      mem_rvalid_i = (!hold && pending.size() > 0) || spurious;
      mem_rdata_i  = (pending.size() > 0) ? pending[0] : 32'h0;
    end
  end

  // Response monitor: every response must match the scoreboard head.
  initial begin
    sb_t e;
    forever begin
      @(negedge clock);
      if (rvalid_o != 0 || (mem_rvalid_i && sb.size() > 0)) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", 32'(rvalid_o), 32'h0);
        end else begin
          e = sb.pop_front();
          $display("rsp: rvalid_o=%b rdata_o=%h (req %0d)", rvalid_o, rdata_o, e.id);
          chk("rvalid_route", 32'(rvalid_o), 32'(2'b01 << e.id));
          chk("rdata", rdata_o, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t      v;
    sram_req_t p;
    sb_t       e;
    int        id;

    for (int a = 0; a < 4096; a++) begin
      mem_arr[a] = 32'hC0DE_0000 | a;
      shadow[a]  = 32'hC0DE_0000 | a;
    end
    mem_arr[5] = 32'hDEAD_BEEF;
    shadow[5]  = 32'hDEAD_BEEF;

    //   rst  mgnt hold req    p0            p1            gnt    mreq
    // single read
    add(1, 1, 0, 2'b00, rd(12'h005), rd(12'h000), 2'b00, 0);
    add(0, 1, 0, 2'b01, rd(12'h005), rd(12'h000), 2'b01, 1);
    add(0, 1, 0, 2'b00, rd(12'h005), rd(12'h000), 2'b00, 0);
    add(0, 1, 0, 2'b00, rd(12'h005), rd(12'h000), 2'b00, 0);
    // contention from reset, grants gated while reset is high
    add(1, 1, 0, 2'b11, rd(12'h020), rd(12'h021), 2'b00, 0);
    add(0, 1, 0, 2'b11, rd(12'h020), rd(12'h021), 2'b01, 1);
    add(0, 1, 0, 2'b11, rd(12'h020), rd(12'h021), 2'b10, 1);
    add(0, 1, 0, 2'b11, rd(12'h020), rd(12'h021), 2'b01, 1);
    add(0, 1, 0, 2'b11, rd(12'h020), rd(12'h021), 2'b10, 1);
    add(0, 1, 0, 2'b00, rd(12'h020), rd(12'h021), 2'b00, 0);
    add(0, 1, 0, 2'b00, rd(12'h020), rd(12'h021), 2'b00, 0);
    // outstanding limit with stalled responses, then pop-through grant
    add(0, 1, 1, 2'b01, rd(12'h040), rd(12'h000), 2'b01, 1);
    add(0, 1, 1, 2'b01, rd(12'h041), rd(12'h000), 2'b01, 1);
    add(0, 1, 1, 2'b01, rd(12'h042), rd(12'h000), 2'b00, 0);
    add(0, 1, 1, 2'b01, rd(12'h042), rd(12'h000), 2'b00, 0);
    add(0, 1, 0, 2'b01, rd(12'h042), rd(12'h000), 2'b01, 1);
    add(0, 1, 0, 2'b00, rd(12'h000), rd(12'h000), 2'b00, 0);
    add(0, 1, 0, 2'b00, rd(12'h000), rd(12'h000), 2'b00, 0);
    add(0, 1, 0, 2'b00, rd(12'h000), rd(12'h000), 2'b00, 0);
    // memory not granting: request visible, no grant, pointer held
    add(0, 0, 0, 2'b11, rd(12'h050), rd(12'h051), 2'b00, 1);
    add(0, 1, 0, 2'b11, rd(12'h050), rd(12'h051), 2'b10, 1);
    add(0, 1, 0, 2'b00, rd(12'h000), rd(12'h000), 2'b00, 0);
    add(0, 1, 0, 2'b00, rd(12'h000), rd(12'h000), 2'b00, 0);
    // write response routing, then read-back of the written byte
    add(1, 1, 0, 2'b00, rd(12'h000), rd(12'h000), 2'b00, 0);
    add(0, 1, 0, 2'b10, rd(12'h000), wr(12'h010, 32'h0000_00A5, 4'b0001), 2'b10, 1);
    add(0, 1, 0, 2'b01, rd(12'h010), rd(12'h000), 2'b01, 1);
    add(0, 1, 0, 2'b00, rd(12'h000), rd(12'h000), 2'b00, 0);
    add(0, 1, 0, 2'b00, rd(12'h000), rd(12'h000), 2'b00, 0);
    // reset mid-flight: tag discarded, pointer and count restart
    add(0, 1, 0, 2'b01, rd(12'h030), rd(12'h000), 2'b01, 1);
    add(1, 1, 0, 2'b01, rd(12'h030), rd(12'h000), 2'b00, 0);
    add(1, 1, 0, 2'b00, rd(12'h000), rd(12'h000), 2'b00, 0);
    add(0, 1, 0, 2'b00, rd(12'h000), rd(12'h000), 2'b00, 0);
    add(0, 1, 0, 2'b00, rd(12'h000), rd(12'h000), 2'b00, 0);
    add(0, 1, 0, 2'b11, rd(12'h060), rd(12'h061), 2'b01, 1);
    add(0, 1, 0, 2'b11, rd(12'h060), rd(12'h061), 2'b10, 1);
    add(0, 1, 0, 2'b00, rd(12'h000), rd(12'h000), 2'b00, 0);
    add(0, 1, 0, 2'b00, rd(12'h000), rd(12'h000), 2'b00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clock);
      #1;
      reset     = v.rst;
      mem_gnt_i = v.mgnt;
      hold      = v.hold;
      req_i     = v.req;
      we_i      = {v.p1.we, v.p0.we};
      addr_i    = {v.p1.addr, v.p0.addr};
      wdata_i   = {v.p1.wdata, v.p0.wdata};
      wmask_i   = {v.p1.wmask, v.p0.wmask};
      if (v.rst) sb.delete();
      id = v.exp_gnt[1] ? 1 : 0;
      p  = (id == 1) ? v.p1 : v.p0;
      if (v.exp_gnt != 2'b00) begin
        e.id = id;
        if (p.we) begin
          for (int b = 0; b < 4; b++)
            if (p.wmask[b]) shadow[p.addr][8*b +: 8] = p.wdata[8*b +: 8];
          e.data = 32'h0;
        end else begin
          e.data = shadow[p.addr];
        end
        sb.push_back(e);
      end
      @(negedge clock);
      $display("vec %0d: rst=%b req_i=%b gnt_o=%b mem_req_o=%b err_o=%b",
               i, v.rst, v.req, gnt_o, mem_req_o, err_o);
      chk($sformatf("gnt_o[%0d]", i), 32'(gnt_o), 32'(v.exp_gnt));
      chk($sformatf("mem_req_o[%0d]", i), 32'(mem_req_o), 32'(v.exp_mreq));
      chk($sformatf("err_o[%0d]", i), 32'(err_o), 32'h0);
      if (v.exp_gnt != 2'b00) begin
        chk($sformatf("mem_addr_o[%0d]", i), 32'(mem_addr_o), 32'(p.addr));
        chk($sformatf("mem_we_o[%0d]", i), 32'(mem_we_o), 32'(p.we));
      end
    end

    // Spurious response: no rvalid_o, sticky err_o until reset.
    @(posedge clock);
    #1 spurious = 1'b1;
    @(negedge clock);
    $display("spurious: mem_rvalid_i=%b rvalid_o=%b err_o=%b", mem_rvalid_i, rvalid_o, err_o);
    chk("spurious_rvalid_o", 32'(rvalid_o), 32'h0);
    chk("spurious_err_before", 32'(err_o), 32'h0);
    @(posedge clock);
    #1 spurious = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      $display("sticky %0d: err_o=%b", k, err_o);
      chk($sformatf("err_sticky_%0d", k), 32'(err_o), 32'h1);
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    $display("post-reset: err_o=%b", err_o);
    chk("err_cleared", 32'(err_o), 32'h0);

    repeat (2) @(negedge clock);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one single-port SRAM request interface (req/gnt/we/addr/wdata/wmask, rdata/rvalid) between NumReq requesters, e.g. core data port and a DMA engine.
- Sits between the requesters' TL-UL SRAM adapters and the data memory array.
- Round-robin arbitration; tracks in-flight requests so each memory response is returned to the requester that issued it, in order.

Parameters:
- NumReq, 2, number of requesters (2..8).
- SramAw, 12, SRAM word address width.
- SramDw, 32, SRAM data width; wmask width is SramDw/8.
- Outstanding, 2, max granted-but-unanswered requests (1..4); depth of the tag FIFO.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- req_i  in  NumReq  per-requester request.
- gnt_o  out  NumReq  per-requester grant (one-hot or zero).
- we_i  in  NumReq  per-requester write enable.
- addr_i  in  NumReq x SramAw  per-requester word address.
- wdata_i  in  NumReq x SramDw  per-requester write data.
- wmask_i  in  NumReq x SramDw/8  per-requester byte mask.
- rvalid_o  out  NumReq  per-requester response valid.
- rdata_o  out  SramDw  response data, broadcast to all requesters.
- mem_req_o  out  1  request to SRAM.
- mem_gnt_i  in  1  SRAM grant (data memory ties to 1).
- mem_we_o  out  1  forwarded write enable.
- mem_addr_o  out  SramAw  forwarded address.
- mem_wdata_o  out  SramDw  forwarded write data.
- mem_wmask_o  out  SramDw/8  forwarded byte mask.
- mem_rdata_i  in  SramDw  SRAM read data.
- mem_rvalid_i  in  1  SRAM response; exactly one per accepted request, reads and writes alike, in order.
- err_o  out  1  sticky: mem_rvalid_i seen with no request outstanding.

Behaviour:
- Reset (synchronous, active-high): rr pointer = 0, tag FIFO empty, count = 0, err_o = 0. All outputs are combinational from these, so gnt_o = 0, rvalid_o = 0, mem_req_o = 0 while reset is high.
- room = (count < Outstanding) OR (count == Outstanding AND mem_rvalid_i). A same-cycle pop frees a slot.
- Winner selection:
  - Combinational, among asserted req_i bits.
  - Search starts at rr pointer, wrapping from NumReq-1 to 0.
  - Lowest index at or after the pointer wins.
- mem_req_o = (|req_i) AND room.
- mem_* payload is muxed from the winner. When there is no winner, payload is don't-care and driven to 0.
- gnt_o[winner] = mem_req_o AND mem_gnt_i; all other bits are 0. Grant and mem handshake occur in the same cycle (zero added latency).
- On handshake:
  - Push winner id into the tag FIFO.
  - rr pointer <= (winner + 1) mod NumReq.
  - No handshake means the pointer is unchanged.
- Requester holds req/payload stable until its gnt_o. Arbitration may change the winner only when the current winner is not yet granted.
- On mem_rvalid_i with count > 0:
  - rvalid_o[FIFO head] = 1 in the same cycle; rdata_o = mem_rdata_i (pass-through).
  - Pop the FIFO.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- mem_rvalid_i with count == 0: no rvalid_o, err_o <= 1 (held until reset).
- Tag FIFO wraps mod Outstanding; read/write pointers are ceil(log2(Outstanding)) bits wide, or 1 bit when Outstanding = 1. count is one bit wider.
- Throughput: with mem_gnt_i = 1, the 1-cycle-latency memory and Outstanding >= 2, one request per cycle is sustained.
- Reset mid-operation: in-flight tags are discarded. Responses arriving after reset deasserts set err_o (the memory's own reset clears its valid).

Decomposition:
- Shared package sram_arb_pkg:
  - Typedef sram_req_t {we, addr, wdata, wmask}, parameterised via localparams SramAw = 12, SramDw = 32.
  - Function rr_pick(req, ptr) returning winner index.
- One sub-module: sram_arb_tag_fifo (depth Outstanding, width $clog2(NumReq)), with push/pop/full/empty/count and same-cycle push+pop.

Test Plan:
- Single read: req_i = 01, addr_i[0] = 0x005, mem returns 0xDEADBEEF next cycle. Expect:
  - gnt_o = 01 in cycle 0.
  - rvalid_o = 01 with rdata_o = 0xDEADBEEF in cycle 1.
  - err_o = 0.
- Contention: req_i = 11 held for 4 cycles from reset. Expect grants 01, 10, 01, 10, and rvalid_o in the same order one cycle later.
- Outstanding limit: Outstanding = 2, mem_gnt_i = 1, memory stalls rvalid for 3 cycles. Expect:
  - 2 grants, then gnt_o = 0 and mem_req_o = 0.
  - On the first mem_rvalid_i, a grant occurs in the same cycle (pop-through).
- Write response routing: req 1 writes 0xA5 with wmask = 0001 at addr 0x010, then req 0 reads 0x010. Expect:
  - rvalid_o = 10, then 01 with rdata_o[7:0] = 0xA5.
- Spurious response: pulse mem_rvalid_i with no request outstanding. Expect err_o = 1 next cycle, rvalid_o = 00, err_o held until reset.
- Reset mid-flight: one read granted, reset asserted the next cycle. Expect:
  - rvalid_o = 00, gnt_o = 00, mem_req_o = 0 during reset.
  - count = 0, rr pointer = 0 after reset.
  - err_o = 0 if no response arrives after reset deasserts.
